// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state types and register map constants for the SIO controller
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_ACK  = 2'd1,
        RX_REL  = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_WAITHI = 2'd1,
        TX_WAITLO = 2'd2
    } tx_state_t;

    localparam int STAT_RX_AVAIL = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_OVR      = 2;
    localparam int STAT_TMO      = 3;
    localparam int STAT_TXDROP   = 4;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

endpackage

// File: rtl/uart_sio_fifo.sv
// rtl/uart_sio_fifo.sv - byte FIFO with simultaneous push/pop, used as the receive buffer
module uart_sio_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [7:0]                 i_wdata,
    input  logic                       i_pop,
    output logic [7:0]                 o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_en, pop_en;

    // Pop only real data; a push into a full FIFO is accepted when a pop frees a slot.
    always_comb begin
        pop_en   = i_pop && (count_q != '0);
        push_en  = i_push && ((count_q != FULL_CNT) || pop_en);
        wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_en  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_full  = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule

// File: rtl/uart_sio_ctrl.sv
// rtl/uart_sio_ctrl.sv - IMSAI-style SIO controller; define UART_SIO_IRQ_EN for interrupt support
module uart_sio_ctrl #(
    parameter int RX_DEPTH    = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_data_rdy,
    output logic       o_rx_rdy_ack,
    input  logic       i_rx_rdy_ack_clr,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    input  logic       i_tx_busy,
    input  logic       i_cpu_addr,
    input  logic       i_cpu_rd,
    input  logic       i_cpu_wr,
    input  logic [7:0] i_cpu_wdata,
    output logic [7:0] o_cpu_rdata,
    output logic       o_irq
);

    import uart_pkg::*;

    localparam int CW = $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    rx_state_t rx_q, rx_d;
    tx_state_t tx_q, tx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       ack_q, ack_d;
    logic       ovr_q, ovr_d, tmo_q, tmo_d, txdrop_q, txdrop_d;
    logic [7:0] hold_q, hold_d, tx_data_q, tx_data_d, rdata_q, rdata_d;
    logic       hold_full_q, hold_full_d, start_q, start_d;
    logic [1:0] irq_en_q, irq_en_d;
    logic       irq_q, irq_d;

    logic       rx_capture, tmo_set, rd_data, rd_stat, wr_data, rx_avail;
    logic [7:0] status;
    logic [7:0] fifo_rdata;
    logic       fifo_full, fifo_empty;
    logic [$clog2(RX_DEPTH):0] fifo_count;

    uart_sio_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (rx_capture),
        .i_wdata (i_rx_data),
        .i_pop   (rd_data),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    // RX handshake: capture once per ready, hold ack until cleared or timed out, then await release.
    always_comb begin
        rx_d       = rx_q;
        ack_d      = ack_q;
        cnt_d      = cnt_q;
        rx_capture = 1'b0;
        tmo_set    = 1'b0;
        case (rx_q)
            RX_IDLE: begin
                if (i_rx_data_rdy && !i_rx_rdy_ack_clr) begin
                    rx_capture = 1'b1;
                    ack_d      = 1'b1;
                    cnt_d      = '0;
                    rx_d       = RX_ACK;
                end
            end
            RX_ACK: begin
                if (i_rx_rdy_ack_clr) begin
                    ack_d = 1'b0;
                    rx_d  = RX_REL;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_set = 1'b1;
                    ack_d   = 1'b0;
                    rx_d    = RX_REL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_REL: begin
                if (!i_rx_rdy_ack_clr) begin
                    rx_d = RX_IDLE;
                end
            end
            default: rx_d = RX_IDLE;
        endcase
    end

    // CPU port decode, read data mux and sticky flags; a same-cycle set beats the read-clear.
    always_comb begin
        rd_data  = i_cpu_rd && (i_cpu_addr == ADDR_DATA);
        rd_stat  = i_cpu_rd && (i_cpu_addr == ADDR_STATUS);
        wr_data  = i_cpu_wr && (i_cpu_addr == ADDR_DATA);
        rx_avail = (fifo_count != '0);

        status                = 8'h00;
        status[7:6]           = irq_en_q;
        status[STAT_RX_AVAIL] = rx_avail;
        status[STAT_TX_EMPTY] = !hold_full_q;
        status[STAT_OVR]      = ovr_q;
        status[STAT_TMO]      = tmo_q;
        status[STAT_TXDROP]   = txdrop_q;

        rdata_d = rdata_q;
        if (rd_data) begin
            rdata_d = fifo_empty ? 8'h00 : fifo_rdata;
        end else if (rd_stat) begin
            rdata_d = status;
        end

        ovr_d    = (ovr_q && !rd_stat) || (rx_capture && fifo_full && !rd_data);
        tmo_d    = (tmo_q && !rd_stat) || tmo_set;
        txdrop_d = (txdrop_q && !rd_stat) || (wr_data && hold_full_q);
    end

    // TX holding register and launch sequencing against the transmitter busy flag.
    always_comb begin
        tx_d        = tx_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_data_d   = tx_data_q;
        start_d     = 1'b0;
        if (wr_data && !hold_full_q) begin
            hold_d      = i_cpu_wdata;
            hold_full_d = 1'b1;
        end
        case (tx_q)
            TX_IDLE: begin
                if (hold_full_q && !i_tx_busy) begin
                    tx_data_d   = hold_q;
                    start_d     = 1'b1;
                    hold_full_d = 1'b0;
                    tx_d        = TX_WAITHI;
                end
            end
            TX_WAITHI: if (i_tx_busy)  tx_d = TX_WAITLO;
            TX_WAITLO: if (!i_tx_busy) tx_d = TX_IDLE;
            default:   tx_d = TX_IDLE;
        endcase
    end

    // Interrupt enable and registered interrupt level.
    always_comb begin
`ifdef UART_SIO_IRQ_EN
        irq_en_d = (i_cpu_wr && (i_cpu_addr == ADDR_STATUS)) ? i_cpu_wdata[1:0] : irq_en_q;
        irq_d    = (rx_avail && irq_en_q[0]) || (!hold_full_q && irq_en_q[1]);
`else
        irq_en_d = 2'b00;
        irq_d    = 1'b0;
`endif
    end

    // State registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_q        <= RX_IDLE;
            tx_q        <= TX_IDLE;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            ovr_q       <= 1'b0;
            tmo_q       <= 1'b0;
            txdrop_q    <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            tx_data_q   <= 8'h00;
            start_q     <= 1'b0;
            rdata_q     <= 8'h00;
            irq_en_q    <= 2'b00;
            irq_q       <= 1'b0;
        end else begin
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            ovr_q       <= ovr_d;
            tmo_q       <= tmo_d;
            txdrop_q    <= txdrop_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_data_q   <= tx_data_d;
            start_q     <= start_d;
            rdata_q     <= rdata_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
        end
    end

    assign o_rx_rdy_ack = ack_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = start_q;
    assign o_cpu_rdata  = rdata_q;
    assign o_irq        = irq_q;

endmodule

// File: tb/tb_uart_sio_ctrl.sv
// tb/tb_uart_sio_ctrl.sv - directed self-checking bench for uart_sio_ctrl
module tb_uart_sio_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       rx_rdy_ack;
    logic       rx_rdy_ack_clr;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       cpu_addr;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;

    uart_sio_ctrl #(.RX_DEPTH(4), .ACK_TIMEOUT(255)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_rx_data        (rx_data),
        .i_rx_data_rdy    (rx_data_rdy),
        .o_rx_rdy_ack     (rx_rdy_ack),
        .i_rx_rdy_ack_clr (rx_rdy_ack_clr),
        .o_tx_data        (tx_data),
        .o_tx_start       (tx_start),
        .i_tx_busy        (tx_busy),
        .i_cpu_addr       (cpu_addr),
        .i_cpu_rd         (cpu_rd),
        .i_cpu_wr         (cpu_wr),
        .i_cpu_wdata      (cpu_wdata),
        .o_cpu_rdata      (cpu_rdata),
        .o_irq            (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_read(input logic addr, output logic [7:0] data);
        cpu_addr = addr;
        cpu_rd   = 1'b1;
        step();
        cpu_rd   = 1'b0;
        data     = cpu_rdata;
    endtask

    task automatic cpu_write(input logic addr, input logic [7:0] d);
        cpu_addr  = addr;
        cpu_wdata = d;
        cpu_wr    = 1'b1;
        step();
        cpu_wr    = 1'b0;
    endtask

    // Well-behaved uart_rx: ready until ack, then clear ready and pulse ack_clr.
    task automatic rx_send(input logic [7:0] b, input string tag);
        rx_data        = b;
        rx_data_rdy    = 1'b1;
        rx_rdy_ack_clr = 1'b0;
        for (int i = 0; i < 10 && !rx_rdy_ack; i++) step();
        check(tag, {15'd0, rx_rdy_ack}, 16'd1);
        rx_data_rdy    = 1'b0;
        rx_rdy_ack_clr = 1'b1;
        step();
        rx_rdy_ack_clr = 1'b0;
        step();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         n;

        reset = 1'b1; rx_data = 8'h00; rx_data_rdy = 1'b0; rx_rdy_ack_clr = 1'b0;
        tx_busy = 1'b0; cpu_addr = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00;
        step(); step();
        reset = 1'b0;

        // Reset state
        check("rst_ack",   {15'd0, rx_rdy_ack}, 16'd0);
        check("rst_start", {15'd0, tx_start}, 16'd0);
        check("rst_txd",   {8'd0, tx_data}, 16'h00);
        check("rst_rdata", {8'd0, cpu_rdata}, 16'h00);
        check("rst_irq",   {15'd0, irq}, 16'd0);
        cpu_read(1'b1, d);
        check("rst_status", {8'd0, d}, 16'h02);

        // Single byte with ack_clr three cycles after ack
        rx_data = 8'h55; rx_data_rdy = 1'b1;
        step();
        n = rx_rdy_ack ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rx_rdy_ack) n++;
        end
        rx_rdy_ack_clr = 1'b1;
        check("hs_ack_cycles", 16'(n), 16'd4);
        step();
        check("hs_ack_drop", {15'd0, rx_rdy_ack}, 16'd0);
        rx_data_rdy = 1'b0;
        step();
        rx_rdy_ack_clr = 1'b0;
        step();
        cpu_read(1'b1, d);
        check("hs_status1", {8'd0, d}, 16'h03);
        cpu_read(1'b0, d);
        check("hs_data", {8'd0, d}, 16'h55);
        cpu_read(1'b1, d);
        check("hs_status2", {8'd0, d}, 16'h02);

        // Overflow: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) rx_send(8'(i), "ovr_hs");
        cpu_read(1'b1, d);
        check("ovr_status", {8'd0, d}, 16'h07);
        for (int i = 1; i <= 4; i++) begin
            cpu_read(1'b0, d);
            check("ovr_data", {8'd0, d}, 16'(i));
        end
        cpu_read(1'b0, d);
        check("ovr_empty_rd", {8'd0, d}, 16'h00);
        cpu_read(1'b1, d);
        check("ovr_cleared", {8'd0, d}, 16'h02);

        // Ack timeout: ack_clr never arrives during the handshake
        rx_data = 8'h99; rx_data_rdy = 1'b1; rx_rdy_ack_clr = 1'b0;
        step();
        n = rx_rdy_ack ? 1 : 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (!rx_rdy_ack) break;
            n++;
        end
        check("tmo_ack_cycles", 16'(n), 16'd255);
        rx_rdy_ack_clr = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("tmo_no_reack", {15'd0, rx_rdy_ack}, 16'd0);
        cpu_read(1'b1, d);
        check("tmo_status", {8'd0, d}, 16'h0B);
        rx_data_rdy = 1'b0; rx_rdy_ack_clr = 1'b0;
        step();
        cpu_read(1'b0, d);
        check("tmo_data", {8'd0, d}, 16'h99);
        cpu_read(1'b1, d);
        check("tmo_single", {8'd0, d}, 16'h02);

        // Transmit path with refill while busy and a dropped third byte
        cpu_write(1'b0, 8'hA5);
        check("tx_no_start_yet", {15'd0, tx_start}, 16'd0);
        step();
        check("tx_start1", {15'd0, tx_start}, 16'd1);
        check("tx_data1", {8'd0, tx_data}, 16'hA5);
        tx_busy = 1'b1;
        cpu_write(1'b0, 8'h3C);
        check("tx_pulse1_end", {15'd0, tx_start}, 16'd0);
        cpu_write(1'b0, 8'h7E);
        step();
        check("tx_hold_busy", {15'd0, tx_start}, 16'd0);
        tx_busy = 1'b0;
        step();
        check("tx_back_idle", {15'd0, tx_start}, 16'd0);
        step();
        check("tx_start2", {15'd0, tx_start}, 16'd1);
        check("tx_data2", {8'd0, tx_data}, 16'h3C);
        tx_busy = 1'b1;
        step();
        check("tx_pulse2_end", {15'd0, tx_start}, 16'd0);
        tx_busy = 1'b0;
        step(); step(); step();
        check("tx_no_third", {15'd0, tx_start}, 16'd0);
        cpu_read(1'b1, d);
        check("tx_status", {8'd0, d}, 16'h12);
        cpu_read(1'b1, d);
        check("tx_status_clr", {8'd0, d}, 16'h02);

        // Reset in the middle of a handshake with two bytes buffered
        rx_send(8'h21, "rst_hs");
        rx_data = 8'h22; rx_data_rdy = 1'b1;
        step();
        check("rstmid_ack_hi", {15'd0, rx_rdy_ack}, 16'd1);
        cpu_read(1'b1, d);
        check("rstmid_pre", {8'd0, d}, 16'h03);
        reset = 1'b1; rx_data_rdy = 1'b0;
        step();
        reset = 1'b0;
        check("rstmid_ack", {15'd0, rx_rdy_ack}, 16'd0);
        check("rstmid_rdata", {8'd0, cpu_rdata}, 16'h00);
        cpu_read(1'b1, d);
        check("rstmid_status", {8'd0, d}, 16'h02);

`ifdef UART_SIO_IRQ_EN
        // Receive interrupt follows FIFO occupancy with one cycle of latency
        cpu_write(1'b1, 8'h01);
        rx_data = 8'h10; rx_data_rdy = 1'b1;
        step();
        check("irq_push_edge", {15'd0, irq}, 16'd0);
        step();
        check("irq_rise", {15'd0, irq}, 16'd1);
        rx_data_rdy = 1'b0; rx_rdy_ack_clr = 1'b1;
        step();
        rx_rdy_ack_clr = 1'b0;
        step();
        cpu_read(1'b1, d);
        check("irq_status", {8'd0, d}, 16'h43);
        cpu_read(1'b0, d);
        check("irq_data", {8'd0, d}, 16'h10);
        check("irq_hold", {15'd0, irq}, 16'd1);
        step();
        check("irq_fall", {15'd0, irq}, 16'd0);
`else
        // Without interrupt support status writes are ignored and irq stays low
        cpu_write(1'b1, 8'h03);
        rx_send(8'h10, "noirq_hs");
        step();
        check("noirq_irq", {15'd0, irq}, 16'd0);
        cpu_read(1'b1, d);
        check("noirq_status", {8'd0, d}, 16'h03);
        cpu_read(1'b0, d);
        check("noirq_data", {8'd0, d}, 16'h10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_sio_ctrl.md
Name: uart_sio_ctrl

Overview:
- Serial I/O controller that sits between the CPU I/O-port decode and the uart_rx/uart_tx pair.
- Sequences the uart_rx four-phase ready/ack handshake and buffers received bytes in a small FIFO.
- Holds one byte for transmit and starts uart_tx.
- Presents a data port and a status port to the CPU, IMSAI SIO style.

Parameters:
- RX_DEPTH, 4, receive FIFO entries; must be a power of 2, minimum 2.
- ACK_TIMEOUT, 255, clock cycles to wait for i_rx_rdy_ack_clr before abandoning a handshake; minimum 2.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  8  byte from uart_rx.
- i_rx_data_rdy  in  1  uart_rx byte-valid flag.
- o_rx_rdy_ack  out  1  ack to uart_rx.
- i_rx_rdy_ack_clr  in  1  uart_rx confirms it has cleared ready.
- o_tx_data  out  8  byte to uart_tx.
- o_tx_start  out  1  one-cycle start pulse to uart_tx.
- i_tx_busy  in  1  uart_tx shifting.
- i_cpu_addr  in  1  0 = data port, 1 = status port.
- i_cpu_rd  in  1  one-cycle read strobe.
- i_cpu_wr  in  1  one-cycle write strobe.
- i_cpu_wdata  in  8  write data.
- o_cpu_rdata  out  8  read data, registered.
- o_irq  out  1  interrupt request; level.

Behaviour:
- Reset values:
  - o_rx_rdy_ack = 0, o_tx_start = 0, o_tx_data = 0x00, o_cpu_rdata = 0x00, o_irq = 0.
  - FIFO empty, tx holding register empty, all sticky flags 0, both FSMs idle.
- Reset mid-handshake drops o_rx_rdy_ack on the next edge; no byte is pushed.
- RX FSM:
  - RX_IDLE: if i_rx_data_rdy = 1 and i_rx_rdy_ack_clr = 0:
    - capture i_rx_data;
    - push it to the FIFO, or set OVR and discard it if the FIFO is full;
    - set o_rx_rdy_ack = 1 and go to RX_ACK.
  - RX_ACK: hold ack and count cycles.
    - On i_rx_rdy_ack_clr = 1: ack = 0, go to RX_REL.
    - When the count reaches ACK_TIMEOUT: set TMO, ack = 0, go to RX_REL.
  - RX_REL: wait for i_rx_rdy_ack_clr = 0, then go to RX_IDLE.
  - The RX_IDLE guard prevents double-capturing a byte after reset or after a timeout.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full (the pop frees the slot) and when empty with a push (the pushed byte is not popped that cycle).
  - Pointers wrap modulo RX_DEPTH; count is log2(RX_DEPTH)+1 bits.
- CPU read, data port (addr 0):
  - o_cpu_rdata = FIFO head, one cycle after i_cpu_rd, and pop.
  - An empty read returns 0x00 with no pop and no error.
- CPU read, status port (addr 1):
  - o_cpu_rdata = {3'b0, TXDROP, TMO, OVR, TX_EMPTY, RX_AVAIL}.
  - TXDROP, TMO and OVR clear on that read; the read returns the pre-clear values.
  - A sticky set in the same cycle as the read wins and stays set.
- CPU write, data port:
  - Holding register empty: load the byte and mark it full.
  - Holding register full: drop the byte and set TXDROP.
- CPU write, status port: handled per the optional feature.
- o_cpu_rdata holds its last value when no read occurs.
- TX FSM:
  - TX_IDLE: holding full and i_tx_busy = 0 -> o_tx_data = holding byte, o_tx_start = 1 for 1 cycle, holding marked empty, go to TX_WAITHI.
  - TX_WAITHI: go to TX_WAITLO on i_tx_busy = 1.
  - TX_WAITLO: go to TX_IDLE on i_tx_busy = 0.
  - The CPU may refill the holding register during TX_WAITHI or TX_WAITLO.
- TX_EMPTY = holding empty; RX_AVAIL = FIFO count != 0.

Optional Feature:
- Macro: UART_SIO_IRQ_EN.
- Defined:
  - A status-port write latches i_cpu_wdata[1:0] into irq_en (reset 0): bit 0 = rx interrupt, bit 1 = tx interrupt.
  - o_irq, registered = (RX_AVAIL & irq_en[0]) | (TX_EMPTY & irq_en[1]).
  - Status bits [7:6] read back irq_en.
- Undefined: o_irq tied 0, status-port writes ignored, status bits [7:6] read 0.

Decomposition:
- Package uart_pkg:
  - rx_state_t (RX_IDLE, RX_ACK, RX_REL);
  - tx_state_t (TX_IDLE, TX_WAITHI, TX_WAITLO);
  - status bit index constants (STAT_RX_AVAIL=0, STAT_TX_EMPTY=1, STAT_OVR=2, STAT_TMO=3, STAT_TXDROP=4);
  - port address constants.
- Sub-module uart_sio_fifo (parameter DEPTH; push/pop/full/empty/count) instantiated for the RX buffer.

Test Plan:
- Model uart_rx presenting 0x55 with ack_clr asserted 3 cycles after ack -> ack high for exactly those cycles; status = 0x03; data read -> 0x55; status -> 0x02.
- Push 5 bytes 0x01..0x05 with no CPU reads (RX_DEPTH=4) -> 5th handshake still completes; status = 0x07; reads return 0x01..0x04, then 0x00; second status read shows OVR cleared.
- Model never asserts ack_clr -> ack drops after 255 cycles; TMO set; byte is in the FIFO; no recapture while data_rdy stays high until ack_clr = 0 is seen.
- Write 0xA5, then 0x3C while the tx model is busy, then 0x7E before TX_IDLE -> single o_tx_start pulses carry 0xA5 then 0x3C; 0x7E dropped; TXDROP = 1.
- Assert i_reset during RX_ACK with FIFO count 2 -> next cycle: ack = 0, status = 0x02, o_cpu_rdata = 0x00.
- With UART_SIO_IRQ_EN: write 0x01 to status, then receive 0x10 -> o_irq rises 1 cycle after the push and falls 1 cycle after the data read.
